// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - sync, debounce and pulse-shape board buttons/switches (optional `COND_PAUSE_LATCH_EN)
// Button FSMs emit one registered pulse per accepted press; paused latch built only with the macro.
module input_conditioner #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reset_push,
  input  logic pause_push,
  input  logic adj,
  input  logic sel,
  output logic reset_pulse,
  output logic pause_pulse,
  output logic paused,
  output logic adj_sync,
  output logic sel_sync
);

  typedef enum logic [1:0] {IDLE, RISE, HELD, FALL} db_state_t;

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0] w_raw;
  logic [3:0] r_s1;
  logic [3:0] r_s2;

  db_state_t        r_state [2];
  logic [CNT_W-1:0] r_cnt   [2];
  logic [1:0]       r_pulse;

  // bit 0 = reset button, bit 1 = pause button, bits 3:2 = switches
  assign w_raw = {sel, adj, pause_push, reset_push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= IDLE;
        r_cnt[b]   <= '0;
      end
      r_pulse <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_pulse[b] <= 1'b0;
        case (r_state[b])
          IDLE: begin
            if (r_s2[b]) begin
              r_state[b] <= RISE;
              r_cnt[b]   <= CNT_ONE;
            end
          end
          RISE: begin
            if (!r_s2[b]) begin
              r_state[b] <= IDLE;
              r_cnt[b]   <= '0;
            end else if (r_cnt[b] == DB_MAX) begin
              r_state[b] <= HELD;
              r_cnt[b]   <= '0;
              r_pulse[b] <= 1'b1;
            end else begin
              r_cnt[b] <= r_cnt[b] + CNT_ONE;
            end
          end
          HELD: begin
            if (!r_s2[b]) begin
              r_state[b] <= FALL;
              r_cnt[b]   <= CNT_ONE;
            end
          end
          FALL: begin
            // a bounce back high aborts the release and never re-pulses
            if (r_s2[b]) begin
              r_state[b] <= HELD;
              r_cnt[b]   <= '0;
            end else if (r_cnt[b] == DB_MAX) begin
              r_state[b] <= IDLE;
              r_cnt[b]   <= '0;
            end else begin
              r_cnt[b] <= r_cnt[b] + CNT_ONE;
            end
          end
          default: begin
            r_state[b] <= IDLE;
            r_cnt[b]   <= '0;
          end
        endcase
      end
    end
  end

  assign reset_pulse = r_pulse[0];
  assign pause_pulse = r_pulse[1];
  assign adj_sync    = r_s2[2];
  assign sel_sync    = r_s2[3];

`ifdef COND_PAUSE_LATCH_EN
  logic r_paused;

  // reset press wins over a simultaneous pause press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paused <= 1'b0;
    end else if (r_pulse[0]) begin
      r_paused <= 1'b0;
    end else if (r_pulse[1]) begin
      r_paused <= ~r_paused;
    end
  end

  assign paused = r_paused;
`else
  assign paused = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner
// Run-length reference model plus directed and randomized button/switch stimulus.
module tb_input_conditioner;

  localparam int DB = 4;
`ifdef COND_PAUSE_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif
  localparam logic [3:0] B_RST = 4'b0001;
  localparam logic [3:0] B_PAU = 4'b0010;
  localparam logic [3:0] S_ADJ = 4'b0100;
  localparam logic [3:0] S_SEL = 4'b1000;

  logic clk = 1'b0;
  logic rst_n;
  logic reset_push, pause_push, adj, sel;
  logic reset_pulse, pause_pulse, paused, adj_sync, sel_sync;

  input_conditioner #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .reset_push(reset_push), .pause_push(pause_push), .adj(adj), .sel(sel),
    .reset_pulse(reset_pulse), .pause_pulse(pause_pulse), .paused(paused),
    .adj_sync(adj_sync), .sel_sync(sel_sync)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference: debounced level flips after DB+1 consecutive disagreeing synchronized samples
  int         m_run [2];
  logic       m_d   [2];
  logic [3:0] m_s1, m_s2;
  logic [1:0] m_pulse;
  logic       m_paused;

  int sidx, cnt_rp, cnt_pp, at_rp, at_pp;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      m_run[b] = 0;
      m_d[b]   = 1'b0;
    end
    m_s1 = '0; m_s2 = '0; m_pulse = '0; m_paused = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [1:0] np;
    logic nps;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (LATCH)
      nps = m_pulse[0] ? 1'b0 : (m_pulse[1] ? !m_paused : m_paused);
    else
      nps = 1'b0;
    for (int b = 0; b < 2; b++) begin
      np[b] = 1'b0;
      if (m_s2[b] !== m_d[b]) begin
        m_run[b]++;
        if (m_run[b] == DB + 1) begin
          m_d[b]   = !m_d[b];
          m_run[b] = 0;
          np[b]    = m_d[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_pulse  = np;
    m_paused = nps;
    m_s2     = m_s1;
    m_s1     = raw;
  endtask

  task automatic check_all();
    chk("reset_pulse", reset_pulse, m_pulse[0]);
    chk("pause_pulse", pause_pulse, m_pulse[1]);
    chk("paused", paused, m_paused);
    chk("adj_sync", adj_sync, m_s2[2]);
    chk("sel_sync", sel_sync, m_s2[3]);
  endtask

  task automatic clr_obs();
    sidx = 0; cnt_rp = 0; cnt_pp = 0; at_rp = -1; at_pp = -1;
  endtask

  task automatic step(input logic [3:0] raw);
    {sel, adj, pause_push, reset_push} = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check_all();
    if (reset_pulse === 1'b1) begin cnt_rp++; at_rp = sidx; end
    if (pause_pulse === 1'b1) begin cnt_pp++; at_pp = sidx; end
    sidx++;
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  initial begin
    logic [7:0] bounce;
    logic [3:0] lvl;
    int rem [4];

    rst_n = 1'b0;
    {sel, adj, pause_push, reset_push} = '0;
    model_clear();
    clr_obs();
    hold(4'b1111, 3);
    #1 rst_n = 1'b1;
    hold(0, 5);

    // clean press, twice
    clr_obs();
    hold(B_PAU, 20);
    chk_int("t1_pulse_count", cnt_pp, 1);
    chk_int("t1_pulse_edge", at_pp, DB + 2);
    chk("t1_paused_set", paused, LATCH);
    hold(0, 10);
    clr_obs();
    hold(B_PAU, 20);
    chk_int("t1b_pulse_count", cnt_pp, 1);
    chk("t1b_paused_clr", paused, 1'b0);
    hold(0, 10);

    // bounce 1,1,1,0,1,1,0,1 then steady
    clr_obs();
    bounce = 8'b1011_0111;
    for (int i = 0; i < 8; i++) step(bounce[i] ? B_PAU : 4'b0000);
    chk_int("t2_no_early_pulse", cnt_pp, 0);
    hold(B_PAU, 12);
    chk_int("t2_pulse_count", cnt_pp, 1);
    chk_int("t2_pulse_edge", at_pp, 7 + DB + 2);
    hold(0, 10);

    // long hold, short release aborted in FALL
    clr_obs();
    hold(B_RST, 1000);
    hold(0, 3);
    hold(B_RST, 20);
    chk_int("t3_reset_pulses", cnt_rp, 1);
    chk("t3_paused", paused, 1'b0);
    hold(0, 10);

    // simultaneous presses while paused
    hold(B_PAU, 10);
    hold(0, 10);
    chk("t4_paused_pre", paused, LATCH);
    clr_obs();
    hold(B_RST | B_PAU, 10);
    chk_int("t4_rp_count", cnt_rp, 1);
    chk_int("t4_pp_count", cnt_pp, 1);
    chk_int("t4_rp_edge", at_rp, DB + 2);
    chk_int("t4_pp_edge", at_pp, DB + 2);
    chk("t4_paused_after", paused, 1'b0);
    hold(0, 10);

    // async reset while pause FSM is mid-RISE, button held through release
    hold(S_ADJ, 4);
    hold(S_ADJ | B_PAU, 5);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("t5_async_adj", adj_sync, 1'b0);
    chk("t5_async_pp", pause_pulse, 1'b0);
    chk("t5_async_paused", paused, 1'b0);
    check_all();
    @(negedge clk);
    hold(B_PAU, 2);
    #1 rst_n = 1'b1;
    clr_obs();
    hold(B_PAU, 12);
    chk_int("t5_pulse_count", cnt_pp, 1);
    chk_int("t5_pulse_edge", at_pp, DB + 2);
    hold(0, 10);

    // switches: 2-flop latency, glitch passes through
    step(S_ADJ | S_SEL);
    chk("t6_adj_e0", adj_sync, 1'b0);
    step(S_ADJ | S_SEL);
    chk("t6_adj_e1", adj_sync, 1'b1);
    chk("t6_sel_e1", sel_sync, 1'b1);
    hold(0, 3);
    chk("t6_adj_low", adj_sync, 1'b0);
    step(S_ADJ);
    step(0);
    chk("t6_glitch_hi", adj_sync, 1'b1);
    step(0);
    chk("t6_glitch_lo", adj_sync, 1'b0);

    // randomized bouncy levels with occasional resets
    lvl = '0;
    for (int k = 0; k < 4; k++) rem[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = 1'($urandom_range(0, 1));
          rem[k] = (k < 2) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 4));
        end
        rem[k]--;
      end
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step(lvl);
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage that sits directly upstream of `stopwatch`. It takes the raw asynchronous board inputs: the two push-buttons `reset_push`/`pause_push` and the two slide switches `adj`/`sel`. It synchronizes all four to `clk`, debounces the two buttons, and emits exactly one single-cycle pulse per debounced press. It also maintains the run/pause level so the stopwatch core sees only clean, clock-aligned controls.

## Interface

Parameters:
- `DB_CYCLES`, default 1_000_000: stable-high/stable-low cycles required to accept a button edge (10 ms at 100 MHz); legal range 2..2^24-1.
- `CNT_W`, default `$clog2(DB_CYCLES+1)`: debounce counter width; derived, not overridden.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: 100 MHz system clock; all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset; release is synchronous to `clk` at system level.
- `reset_push` input 1: raw, bouncy reset button, active-high.
- `pause_push` input 1: raw, bouncy pause button, active-high.
- `adj` input 1: raw adjust-mode switch.
- `sel` input 1: raw minutes/seconds select switch.
- `reset_pulse` output 1: one-cycle pulse per accepted reset press.
- `pause_pulse` output 1: one-cycle pulse per accepted pause press.
- `paused` output 1: 1 = stopwatch held, 0 = running (see Configuration).
- `adj_sync` output 1: 2-flop-synchronized `adj`.
- `sel_sync` output 1: 2-flop-synchronized `sel`.

## Operation

- Every raw input passes through a 2-flop synchronizer (`s1`, `s2`); the logic below uses only `s2`.
- Each button has an independent 4-state FSM and a `CNT_W` counter:
  - IDLE (stable low): if `s2`=1, go to RISE with cnt=1.
  - RISE: if `s2`=0, go to IDLE with cnt=0. Else if cnt==DB_CYCLES, go to HELD and register pulse=1. Else cnt+1.
  - HELD (stable high): if `s2`=0, go to FALL with cnt=1.
  - FALL: if `s2`=1, go to HELD with cnt=0. Else if cnt==DB_CYCLES, go to IDLE. Else cnt+1.
- The pulse is registered and is high only on the cycle immediately after the RISE→HELD transition. Release never produces a pulse. A held button produces exactly one pulse.
- Bounce shorter than DB_CYCLES in RISE or FALL is absorbed: the counter restarts, and no pulse or state change occurs.
- Counter saturation: cnt never exceeds DB_CYCLES and never wraps.
- `paused` is updated on the clock edge after a pulse is seen:
  - `pause_pulse` toggles it.
  - `reset_pulse` forces it to 0.
  - If both pulses are high in the same cycle, reset wins and `paused`=0.
- `rst_n`=0, including mid-debounce:
  - All FSMs go to IDLE, all counters and synchronizer flops to 0.
  - `reset_pulse`=`pause_pulse`=`paused`=`adj_sync`=`sel_sync`=0.
  - A press in progress is discarded; a button still held at reset release is re-debounced from IDLE and does yield one pulse.

## Timing

- Synchronizer latency: a raw change sampled at edge E0 appears on `s2`, `adj_sync` and `sel_sync` after edge E1.
- Press latency: the raw button is first sampled high at E0 and stays high. The FSM enters RISE at E2 and reaches cnt=DB_CYCLES at E(DB_CYCLES+1). The pulse is high for exactly one cycle after edge E(DB_CYCLES+2).
- `paused` changes at the edge after the pulse, i.e. E(DB_CYCLES+3).
- Release latency: DB_CYCLES+2 edges from the first low sample to IDLE. A new press is accepted only from IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- `COND_PAUSE_LATCH_EN` defined: the `paused` toggle register is built as described in Operation.
- `COND_PAUSE_LATCH_EN` undefined:
  - The toggle register is removed and `paused` is tied to 0.
  - `stopwatch` must toggle its own pause state from `pause_pulse`.
  - All other behaviour is identical.

## Test plan

All scenarios use DB_CYCLES=4, 10 ns clock and `COND_PAUSE_LATCH_EN` defined unless stated.

1. Clean press: `pause_push` high for 20 cycles from E0 → `pause_pulse`=1 only after E6; `paused` 0→1 at E7; a second identical press → `paused` 1→0.
2. Bounce: `pause_push` pattern 1,1,1,0,1,1,0,1 then steady 1 → no pulse during the bounce; exactly one pulse, 6 edges after the last 0→1 sample.
3. Long hold and release: `reset_push` high for 1000 cycles, low for 3 cycles, then high again → exactly one `reset_pulse` in total, because FALL is aborted back to HELD.
4. Simultaneous: both buttons pressed on the same cycle while `paused`=1 → both pulses in the same cycle; `paused`=0 on the next edge. Repeat with `COND_PAUSE_LATCH_EN` undefined → `paused` stays 0 throughout.
5. Reset mid-operation: assert `rst_n`=0 while the pause FSM is in RISE with cnt=3 → all outputs 0 immediately (asynchronous). With the button held through reset release, one pulse occurs DB_CYCLES+2 edges after the first post-release sample.
6. Switches: toggle `adj` and `sel` at E0 → `adj_sync`/`sel_sync` follow after E1; a 1-cycle glitch on `adj` → a 1-cycle glitch on `adj_sync` (synchronized, not debounced).
